// File: rtl/ntt_cal.sv
// Forward-NTT Cooley-Tukey butterfly for Kyber: t = mont(zeta*f1), r2 = f2 + t, r1 = f2 - t.
// Three-stage stallable pipeline with valid/ready handshake and a pass-through address tag.
module ntt_cal #(
  parameter int TAG_W = 8,
  parameter int KQ    = 3329,
  parameter int QINV  = -3327
) (
  input  logic                    clk,
  input  logic                    set,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      f1,
  input  logic signed [15:0]      f2,
  input  logic signed [15:0]      zeta,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [15:0]      r1,
  output logic signed [15:0]      r2,
  output logic [TAG_W-1:0]        out_tag
);

  localparam logic [15:0] QINV_L = QINV[15:0];

  logic                   adv;
  logic signed [31:0]     p_next;
  logic [15:0]            u_next;
  logic signed [31:0]     u_ext;
  logic signed [31:0]     diff;
  logic signed [15:0]     t_val;
  logic signed [15:0]     r1_next;
  logic signed [15:0]     r2_next;

  logic                   v1_reg;
  logic signed [15:0]     f2_s1_reg;
  logic [TAG_W-1:0]       tag_s1_reg;
  logic signed [31:0]     p_s1_reg;

  logic                   v2_reg;
  logic signed [15:0]     f2_s2_reg;
  logic [TAG_W-1:0]       tag_s2_reg;
  logic signed [31:0]     p_s2_reg;
  logic [15:0]            u_s2_reg;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Full 32-bit signed product: -32768 * -32768 = 2^30 still fits.
  assign p_next = $signed({{16{zeta[15]}}, zeta}) * $signed({{16{f1[15]}}, f1});

  // Only the low 16 bits of low16(p) * QINV matter, so an unsigned 16-bit multiply suffices.
  assign u_next = 16'(p_s1_reg[15:0] * QINV_L);

  // p - u*q is an exact multiple of 2^16; the quotient lies in (-q, q).
  assign u_ext   = $signed({{16{u_s2_reg[15]}}, u_s2_reg});
  assign diff    = p_s2_reg - u_ext * KQ;
  assign t_val   = 16'(diff >>> 16);
  assign r2_next = f2_s2_reg + t_val;
  assign r1_next = f2_s2_reg - t_val;

  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      v1_reg     <= 1'b0;
      f2_s1_reg  <= '0;
      tag_s1_reg <= '0;
      p_s1_reg   <= '0;
      v2_reg     <= 1'b0;
      f2_s2_reg  <= '0;
      tag_s2_reg <= '0;
      p_s2_reg   <= '0;
      u_s2_reg   <= '0;
      out_valid  <= 1'b0;
      r1         <= '0;
      r2         <= '0;
      out_tag    <= '0;
    end else if (adv) begin
      v1_reg     <= in_valid;
      f2_s1_reg  <= f2;
      tag_s1_reg <= in_tag;
      p_s1_reg   <= p_next;

      v2_reg     <= v1_reg;
      f2_s2_reg  <= f2_s1_reg;
      tag_s2_reg <= tag_s1_reg;
      p_s2_reg   <= p_s1_reg;
      u_s2_reg   <= u_next;

      out_valid  <= v2_reg;
      r1         <= r1_next;
      r2         <= r2_next;
      out_tag    <= tag_s2_reg;
    end
  end

endmodule

// File: tb/tb_ntt_cal.sv
// Directed self-checking bench for the ntt_cal forward butterfly.
// Each scenario task drives its own stimulus and compares inline.
module tb_ntt_cal;

  logic               clk = 1'b0;
  logic               set;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] f1;
  logic signed [15:0] f2;
  logic signed [15:0] zeta;
  logic [7:0]         in_tag;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] r1;
  logic signed [15:0] r2;
  logic [7:0]         out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [15:0] sv_f1 [256];
  logic signed [15:0] sv_f2 [256];
  logic signed [15:0] sv_z  [256];

  ntt_cal #(.TAG_W(8), .KQ(3329), .QINV(-3327)) dut (
    .clk       (clk),
    .set       (set),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f1        (f1),
    .f2        (f2),
    .zeta      (zeta),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r1        (r1),
    .r2        (r2),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  // Kyber reference: fqmul(zeta, a) = montgomery_reduce((int32)zeta * a)
  function automatic shortint ref_t(input shortint z, input shortint a1);
    int      a;
    int      m;
    shortint u;
    a = int'(z) * int'(a1);
    m = a * -3327;
    u = shortint'(m);
    return shortint'((a - int'(u) * 3329) >>> 16);
  endfunction

  task automatic init_vectors();
    for (int i = 0; i < 256; i++) begin
      sv_f1[i] = 16'(i * 257 - 30000);
      sv_f2[i] = 16'(12000 - i * 129);
      sv_z[i]  = 16'((i * 1103) % 3329 - 1664);
    end
    sv_f1[0] = -16'sd32768;
    sv_z[0]  = -16'sd32768;
    sv_f2[1] = 16'sd32767;
    sv_z[1]  = 16'sd2285;
    sv_f1[1] = 16'sd3000;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%0d exp=0", out_valid); end
    n_cmp++; if (r1 !== 16'sd0) begin n_bad++; $display("FAIL reset_r1 got=%0d exp=0", r1); end
    n_cmp++; if (r2 !== 16'sd0) begin n_bad++; $display("FAIL reset_r2 got=%0d exp=0", r2); end
    n_cmp++; if (out_tag !== 8'd0) begin n_bad++; $display("FAIL reset_out_tag got=%0d exp=0", out_tag); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%0d exp=1", in_ready); end
    @(negedge clk);
    set = 1'b0;
    $display("reset released");
  endtask

  task automatic test_directed();
    logic signed [15:0] tz  [5] = '{16'sd2285, 16'sd2285, 16'sd0, 16'sd2285, -16'sd32768};
    logic signed [15:0] tf1 [5] = '{16'sd100, -16'sd100, 16'sd1234, 16'sd100, -16'sd32768};
    logic signed [15:0] tf2 [5] = '{16'sd500, 16'sd0, -16'sd77, 16'sd32767, 16'sd0};
    logic [7:0]         ttg [5] = '{8'd5, 8'd17, 8'd42, 8'd200, 8'd255};
    logic signed [15:0] er1 [5] = '{16'sd400, 16'sd100, -16'sd77, 16'sd32667, -16'sd16384};
    logic signed [15:0] er2 [5] = '{16'sd600, -16'sd100, -16'sd77, -16'sd32669, 16'sd16384};
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; zeta = tz[k]; f1 = tf1[k]; f2 = tf2[k]; in_tag = ttg[k];
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_early_valid got=%0d exp=0", k, out_valid); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dir%0d_out_valid got=%0d exp=1", k, out_valid); end
      n_cmp++; if (r1 !== er1[k]) begin n_bad++; $display("FAIL dir%0d_r1 got=%0d exp=%0d", k, r1, er1[k]); end
      n_cmp++; if (r2 !== er2[k]) begin n_bad++; $display("FAIL dir%0d_r2 got=%0d exp=%0d", k, r2, er2[k]); end
      n_cmp++; if (out_tag !== ttg[k]) begin n_bad++; $display("FAIL dir%0d_tag got=%0d exp=%0d", k, out_tag, ttg[k]); end
      $display("directed zeta=%0d f1=%0d f2=%0d tag=%0d -> r1=%0d r2=%0d", tz[k], tf1[k], tf2[k], ttg[k], r1, r2);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    int                 idx;
    shortint            t;
    logic signed [15:0] e1;
    logic signed [15:0] e2;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int c = 0; c < 260; c++) begin
      @(negedge clk);
      idx = c - 3;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready cyc=%0d got=%0d exp=1", c, in_ready); end
      if (idx >= 0 && idx < 256) begin
        t  = ref_t(sv_z[idx], sv_f1[idx]);
        e1 = 16'(sv_f2[idx] - t);
        e2 = 16'(sv_f2[idx] + t);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid cyc=%0d got=%0d exp=1", c, out_valid); end
        n_cmp++; if (out_tag !== 8'(idx)) begin n_bad++; $display("FAIL stream_tag cyc=%0d got=%0d exp=%0d", c, out_tag, idx); end
        n_cmp++; if (r1 !== e1) begin n_bad++; $display("FAIL stream_r1 tag=%0d got=%0d exp=%0d", idx, r1, e1); end
        n_cmp++; if (r2 !== e2) begin n_bad++; $display("FAIL stream_r2 tag=%0d got=%0d exp=%0d", idx, r2, e2); end
        $display("stream tag=%0d r1=%0d r2=%0d", out_tag, r1, r2);
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_idle_valid cyc=%0d got=%0d exp=0", c, out_valid); end
      end
      if (c < 256) begin
        in_valid = 1'b1; zeta = sv_z[c]; f1 = sv_f1[c]; f2 = sv_f2[c]; in_tag = 8'(c);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    int                 n_pairs = 60;
    int                 next_in = 0;
    int                 rx = 0;
    int                 exp_q [$];
    int                 idx;
    shortint            t;
    logic signed [15:0] e1;
    logic signed [15:0] e2;
    logic               hold_prev = 1'b0;
    logic signed [15:0] p_r1;
    logic signed [15:0] p_r2;
    logic [7:0]         p_tag;
    for (int c = 0; c < 600 && rx < n_pairs; c++) begin
      @(negedge clk);
      if (c < 5) out_ready = 1'b1;
      else if (c < 15) out_ready = 1'b0;
      else out_ready = 1'($urandom_range(0, 1));
      in_valid = (next_in < n_pairs);
      if (next_in < n_pairs) begin
        zeta = sv_z[next_in]; f1 = sv_f1[next_in]; f2 = sv_f2[next_in]; in_tag = 8'(next_in);
      end
      #1;
      if (hold_prev) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid cyc=%0d got=%0d exp=1", c, out_valid); end
        n_cmp++; if (r1 !== p_r1 || r2 !== p_r2 || out_tag !== p_tag)
          begin n_bad++; $display("FAIL bp_hold_data cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c, r1, r2, out_tag, p_r1, p_r2, p_tag); end
      end
      if (c >= 5 && c < 15) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_stalled cyc=%0d got=%0d exp=0", c, in_ready); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL bp_unexpected got tag=%0d exp=none", out_tag);
        end else begin
          idx = exp_q.pop_front();
          t   = ref_t(sv_z[idx], sv_f1[idx]);
          e1  = 16'(sv_f2[idx] - t);
          e2  = 16'(sv_f2[idx] + t);
          n_cmp++; if (out_tag !== 8'(idx)) begin n_bad++; $display("FAIL bp_tag got=%0d exp=%0d", out_tag, idx); end
          n_cmp++; if (r1 !== e1 || r2 !== e2) begin n_bad++; $display("FAIL bp_data tag=%0d got=%0d/%0d exp=%0d/%0d", idx, r1, r2, e1, e2); end
          $display("backpressure tag=%0d r1=%0d r2=%0d", out_tag, r1, r2);
          rx++;
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(next_in);
        next_in++;
      end
      hold_prev = (out_valid === 1'b1) && !out_ready;
      p_r1 = r1; p_r2 = r2; p_tag = out_tag;
    end
    n_cmp++; if (rx != n_pairs) begin n_bad++; $display("FAIL bp_received got=%0d exp=%0d", rx, n_pairs); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained_valid got=%0d exp=0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; zeta = sv_z[10 + k]; f1 = sv_f1[10 + k]; f2 = sv_f2[10 + k]; in_tag = 8'(10 + k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid got=%0d exp=1", out_valid); end
    #1 set = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async_valid got=%0d exp=0", out_valid); end
    n_cmp++; if (r1 !== 16'sd0 || r2 !== 16'sd0) begin n_bad++; $display("FAIL rst_async_data got=%0d/%0d exp=0/0", r1, r2); end
    n_cmp++; if (out_tag !== 8'd0) begin n_bad++; $display("FAIL rst_async_tag got=%0d exp=0", out_tag); end
    $display("reset asserted with pairs in flight");
    @(negedge clk);
    set = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stale cyc=%0d got=%0d exp=0", c, out_valid); end
    end
    in_valid = 1'b1; zeta = 16'sd2285; f1 = 16'sd100; f2 = 16'sd500; in_tag = 8'd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_new_early got=%0d exp=0", out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_new_valid got=%0d exp=1", out_valid); end
    n_cmp++; if (r1 !== 16'sd400 || r2 !== 16'sd600 || out_tag !== 8'd5)
      begin n_bad++; $display("FAIL rst_new_data got=%0d/%0d/%0d exp=400/600/5", r1, r2, out_tag); end
    $display("post-reset tag=%0d r1=%0d r2=%0d", out_tag, r1, r2);
  endtask

  initial begin
    set = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    f1 = '0; f2 = '0; zeta = '0; in_tag = '0;
    init_vectors();
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ntt_cal.md
Name: ntt_cal

Overview:
- Forward-NTT Cooley-Tukey butterfly for the Kyber polynomial datapath. It is the forward counterpart of the inverse-NTT Gentleman-Sande butterfly.
- Per accepted pair it computes:
  - t = montgomery(zeta * f[j+len])
  - f[j] <- f[j] + t
  - f[j+len] <- f[j] - t
- It is a fully pipelined, stallable 3-stage unit with a valid/ready handshake. A coefficient-address tag travels alongside each pair so the NTT controller can write results back to coefficient RAM.

Parameters:
- TAG_W, 8, width of the pass-through address tag (256 coefficients).
- KQ, 3329, Kyber modulus q.
- QINV, -3327, q^-1 mod 2^16 (signed 16-bit), used by the Montgomery reduction.

Ports:
- clk  input  1  rising-edge clock.
- set  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input pair valid.
- in_ready  output  1  unit can accept the input pair this cycle.
- f1  input  16  signed f[j+len].
- f2  input  16  signed f[j].
- zeta  input  16  signed twiddle, Montgomery domain.
- in_tag  input  TAG_W  caller address tag.
- out_valid  output  1  result pair valid.
- out_ready  input  1  downstream accepts the result.
- r1  output  16  signed new f[j+len] = f2 - t.
- r2  output  16  signed new f[j] = f2 + t.
- out_tag  output  TAG_W  tag of the result pair.

Behaviour:
- Clock and reset: one clock, clk. Reset is set, asynchronous and active-high. While set=1, all stage valid bits clear and r1, r2, out_tag and out_valid read 0. Data registers may be cleared too. A reset mid-operation discards every in-flight pair; nothing emerges afterwards.
- Advance condition: adv = !out_valid || out_ready.
  - in_ready = adv, combinational, with no dependence on in_valid.
  - When adv=1, all three stages shift together.
  - When adv=0, every stage register holds, and r1/r2/out_tag stay stable while out_valid=1.
- Input acceptance: a pair is accepted on a clock edge where in_valid && in_ready. When in_valid=0 and adv=1, a bubble (valid=0) enters stage 1.
- Stage 1: register f2, in_tag, valid, and p = zeta*f1 as a 32-bit signed product (full precision, no truncation).
- Stage 2: register p and u = low16(low16(p) * QINV), interpreted as signed 16-bit.
- Stage 3 (output registers):
  - t = (p - u*KQ) >>> 16, arithmetic shift, 32-bit intermediate, t in (-q, q).
  - r2 <= f2 + t; r1 <= f2 - t.
  - Both are 16-bit two's-complement and wrap on overflow. No Barrett reduction is applied here, matching the Kyber reference forward NTT.
- Latency and throughput:
  - An accepted pair appears with out_valid=1 exactly 3 cycles after acceptance, counting no-stall cycles only.
  - Throughput is 1 pair/clock while out_ready=1.
- Tags and ordering: order is preserved and out_tag always matches the pair it travels with.
- Simultaneous accept and emit: a stage-3 pair consumed in the same cycle a new pair is accepted is legal. No pair is lost or duplicated.
- Back-pressure: out_ready may toggle on any cycle. A result is held until accepted, and no input is accepted while the unit is stalled.
- Arithmetic boundary cases:
  - zeta=0 gives t=0, so r1 = r2 = f2.
  - f1 = -32768 with zeta = -32768 gives p = 2^30; this must be handled without overflow of the 32-bit intermediate.

Test Plan:
- Basic: zeta=2285, f1=100, f2=500, tag=5, out_ready=1 -> after 3 cycles out_valid=1, r2=600, r1=400, out_tag=5.
- Negative operand: zeta=2285, f1=-100, f2=0 -> r2=-100, r1=100. Zero twiddle: zeta=0, f1=1234, f2=-77 -> r1=r2=-77.
- Streaming: 256 back-to-back pairs with tags 0..255 and out_ready=1 -> 256 results in tag order, one per cycle starting at cycle 3, each matching a C reference model of the Kyber ntt butterfly.
- Back-pressure:
  - Setup: fill the pipe, then hold out_ready=0 for 10 cycles while in_valid=1, then random out_ready.
  - Required: in_ready=0 throughout the hold; outputs stable while out_valid=1 and out_ready=0; no loss, no duplication, order preserved.
- Wrap: zeta=2285, f1=100, f2=32767 -> r2=-32669, r1=32667.
- Reset: assert set asynchronously with 3 pairs in flight -> out_valid=0, r1=r2=0 immediately. After release, no stale results appear, and the first new pair emerges with 3-cycle latency.
